// File: rtl/regfile_wb.sv
// Architectural integer register file fed by the writeback stage.
// Two combinational read ports with same-cycle write bypass, x0 hard-wired to zero, and a committed-write counter.
module regfile_wb #(
    parameter int NREG  = 32,
    parameter int WIDTH = 64,
    parameter int CNTW  = 64,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             regwrite,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] result,
    output logic [CNTW-1:0]  wcount
);

    logic [WIDTH-1:0] regs_r [NREG];
    logic [CNTW-1:0]  wcount_r;
    logic             we_s;
    logic             byp1_s;
    logic             byp2_s;

    // A write commits only to x1..x(NREG-1).
    // Bypass is also gated by reset so that every read returns 0 while reset is held.
    assign we_s   = regwrite && (wa != '0);
    assign byp1_s = reset && we_s && (wa == ra1);
    assign byp2_s = reset && we_s && (wa == ra2);

    // Register array and committed-write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
            wcount_r <= '0;
        end else if (we_s) begin
            regs_r[wa] <= result;
            wcount_r   <= wcount_r + CNTW'(1);
        end else begin
            wcount_r <= wcount_r;
        end
    end

    // Read port 1: x0 reads 0, then the in-flight write, then stored data.
    always_comb begin
        rd1 = '0;
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (byp1_s) begin
            rd1 = result;
        end else begin
            rd1 = regs_r[ra1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = '0;
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (byp2_s) begin
            rd2 = result;
        end else begin
            rd2 = regs_r[ra2];
        end
    end

    assign wcount = wcount_r;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed and random self-checking bench for regfile_wb.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ra1 = 5'd0;
    logic [4:0]  ra2 = 5'd0;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        regwrite = 1'b0;
    logic [4:0]  wa = 5'd0;
    logic [63:0] result = 64'd0;
    logic [63:0] wcount;

    int total = 0;
    int bad = 0;

    logic [63:0] model [32];
    logic [63:0] mcount;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .regwrite(regwrite), .wa(wa), .result(result), .wcount(wcount)
    );

    task automatic test_reset();
        #2;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            total++;
            if (rd1 !== 64'd0 || rd2 !== 64'd0) begin
                bad++;
                $display("FAIL reset_rd a=%0d rd1=%h rd2=%h expected 0", a, rd1, rd2);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (wcount !== 64'd0) begin
            bad++;
            $display("FAIL reset_wcount got %0d expected 0", wcount);
        end
        for (int a = 0; a < 32; a += 7) begin
            ra1 = 5'(a);
            #1;
            total++;
            if (rd1 !== 64'd0) begin
                bad++;
                $display("FAIL release_rd a=%0d got %h expected 0", a, rd1);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        regwrite = 1'b1; wa = 5'd5; result = 64'hDEAD_BEEF_0000_0001; ra1 = 5'd5;
        #1;
        total++;
        if (rd1 !== 64'hDEAD_BEEF_0000_0001) begin
            bad++;
            $display("FAIL bypass_rd1 got %h expected deadbeef00000001", rd1);
        end
        @(posedge clk);
        @(negedge clk);
        regwrite = 1'b0; result = 64'd0;
        #1;
        total++;
        if (rd1 !== 64'hDEAD_BEEF_0000_0001) begin
            bad++;
            $display("FAIL stored_rd1 got %h expected deadbeef00000001", rd1);
        end
        total++;
        if (wcount !== 64'd1) begin
            bad++;
            $display("FAIL bypass_wcount got %0d expected 1", wcount);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        regwrite = 1'b1; wa = 5'd0; result = 64'hFFFF_FFFF_FFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        total++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0) begin
            bad++;
            $display("FAIL x0_during rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        @(posedge clk);
        @(negedge clk);
        regwrite = 1'b0;
        #1;
        total++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0) begin
            bad++;
            $display("FAIL x0_after rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        total++;
        if (wcount !== 64'd1) begin
            bad++;
            $display("FAIL x0_wcount got %0d expected 1", wcount);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        regwrite = 1'b1; wa = 5'd7; result = 64'd1;
        @(posedge clk);
        @(negedge clk);
        result = 64'd2; ra1 = 5'd7; ra2 = 5'd7;
        #1;
        total++;
        if (rd1 !== 64'd2 || rd2 !== 64'd2) begin
            bad++;
            $display("FAIL waw_bypass rd1=%h rd2=%h expected 2", rd1, rd2);
        end
        @(posedge clk);
        @(negedge clk);
        regwrite = 1'b0; result = 64'd0; ra2 = 5'd5;
        #1;
        total++;
        if (rd1 !== 64'd2) begin
            bad++;
            $display("FAIL waw_stored got %h expected 2", rd1);
        end
        total++;
        if (rd2 !== 64'hDEAD_BEEF_0000_0001) begin
            bad++;
            $display("FAIL x5_kept got %h expected deadbeef00000001", rd2);
        end
        total++;
        if (wcount !== 64'd3) begin
            bad++;
            $display("FAIL waw_wcount got %0d expected 3", wcount);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        regwrite = 1'b1; wa = 5'd10; result = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        result = 64'h5678; ra1 = 5'd10; ra2 = 5'd7;
        #1;
        total++;
        if (rd1 !== 64'h5678) begin
            bad++;
            $display("FAIL pre_reset_bypass got %h expected 5678", rd1);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_rd rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        total++;
        if (wcount !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_wcount got %0d expected 0", wcount);
        end
        @(posedge clk);
        @(negedge clk);
        regwrite = 1'b0; reset = 1'b1; ra2 = 5'd5;
        #1;
        total++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0) begin
            bad++;
            $display("FAIL post_reset_rd rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        total++;
        if (wcount !== 64'd0) begin
            bad++;
            $display("FAIL post_reset_wcount got %0d expected 0", wcount);
        end
    endtask

    task automatic test_random();
        logic [63:0] e1;
        logic [63:0] e2;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        mcount = 64'd0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ra1 = 5'($urandom_range(31, 0));
            ra2 = 5'($urandom_range(31, 0));
            wa = (c % 5 == 0) ? ra1 : 5'($urandom_range(31, 0));
            regwrite = 1'($urandom_range(1, 0));
            result = {$urandom, $urandom};
            e1 = (ra1 == 5'd0) ? 64'd0 : (regwrite && wa == ra1) ? result : model[ra1];
            e2 = (ra2 == 5'd0) ? 64'd0 : (regwrite && wa == ra2) ? result : model[ra2];
            #1;
            total++;
            if (rd1 !== e1) begin
                bad++;
                $display("FAIL rand_rd1 cyc=%0d ra1=%0d got %h expected %h", c, ra1, rd1, e1);
            end
            total++;
            if (rd2 !== e2) begin
                bad++;
                $display("FAIL rand_rd2 cyc=%0d ra2=%0d got %h expected %h", c, ra2, rd2, e2);
            end
            total++;
            if (wcount !== mcount) begin
                bad++;
                $display("FAIL rand_wcount cyc=%0d got %0d expected %0d", c, wcount, mcount);
            end
            @(posedge clk);
            if (regwrite && wa != 5'd0) begin
                model[wa] = result;
                mcount = mcount + 64'd1;
            end
        end
        @(negedge clk);
        regwrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
